// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-issue MIPS ALU front end.
// Decodes one R/I-type arithmetic/logic instruction, reads operands from a
// 32-entry register file, pulses alu_start, waits for alu_finished and writes
// the result back, trapping on signed overflow and on illegal encodings.
module alu_issue_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  output logic                 instr_ready,
  output logic                 alu_start,
  output logic [WORD_SIZE-1:0] alu_input_a,
  output logic [WORD_SIZE-1:0] alu_input_b,
  output logic [3:0]           alu_control,
  input  logic                 alu_finished,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_err_overflow,
  input  logic                 alu_err_invalid_control,
  output logic                 wb_valid,
  output logic [REG_ADDR-1:0]  wb_addr,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 illegal_instr,
  output logic                 overflow_trap,
  input  logic [REG_ADDR-1:0]  debug_addr,
  output logic [WORD_SIZE-1:0] debug_data
);

  localparam int NUM_REGS = 2**REG_ADDR;

  // Control codes shared with alu_32
  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_ADDU = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t state, state_nxt;

  // Register file; entry 0 is never written and reads as zero.
  logic [WORD_SIZE-1:0] rf [NUM_REGS];

  // Instruction fields
  logic [5:0]           opcode, funct;
  logic [REG_ADDR-1:0]  rs, rt, rd;
  logic [15:0]          imm;
  logic [4:0]           unused_shamt;
  logic [WORD_SIZE-1:0] rs_val, rt_val, imm_sext, imm_zext;

  assign opcode       = instr[31:26];
  assign rs           = REG_ADDR'(instr[25:21]);
  assign rt           = REG_ADDR'(instr[20:16]);
  assign rd           = REG_ADDR'(instr[15:11]);
  assign unused_shamt = instr[10:6];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign imm_sext     = {{(WORD_SIZE-16){imm[15]}}, imm};
  assign imm_zext     = {{(WORD_SIZE-16){1'b0}}, imm};

  assign rs_val     = (rs == '0) ? '0 : rf[rs];
  assign rt_val     = (rt == '0) ? '0 : rf[rt];
  assign debug_data = (debug_addr == '0) ? '0 : rf[debug_addr];

  // Decoded instruction
  logic                 dec_legal;
  logic [3:0]           dec_ctrl;
  logic [REG_ADDR-1:0]  dec_dest;
  logic [WORD_SIZE-1:0] dec_b;

  // Latched issue/completion state
  logic [REG_ADDR-1:0]  dest_q;
  logic [WORD_SIZE-1:0] res_q;
  logic                 ovf_q, inv_q, illegal_q;

  logic accept, reject, signed_op, wb_write;

  // Decode the offered instruction to control code, operand B and destination
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = CTL_AND;
    dec_dest  = rt;
    dec_b     = imm_sext;
    case (opcode)
      6'h00: begin
        dec_dest  = rd;
        dec_b     = rt_val;
        dec_legal = 1'b1;
        case (funct)
          6'h24:   dec_ctrl = CTL_AND;
          6'h25:   dec_ctrl = CTL_OR;
          6'h27:   dec_ctrl = CTL_NOR;
          6'h20:   dec_ctrl = CTL_ADD;
          6'h21:   dec_ctrl = CTL_ADDU;
          6'h22:   dec_ctrl = CTL_SUB;
          6'h2A:   dec_ctrl = CTL_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_legal = 1'b1; dec_ctrl = CTL_ADD;  dec_b = imm_sext; end
      6'h09: begin dec_legal = 1'b1; dec_ctrl = CTL_ADDU; dec_b = imm_sext; end
      6'h0A: begin dec_legal = 1'b1; dec_ctrl = CTL_SLT;  dec_b = imm_sext; end
      6'h0C: begin dec_legal = 1'b1; dec_ctrl = CTL_AND;  dec_b = imm_zext; end
      6'h0D: begin dec_legal = 1'b1; dec_ctrl = CTL_OR;   dec_b = imm_zext; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && instr_valid && dec_legal;
  assign reject = (state == IDLE) && instr_valid && !dec_legal;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; alu_finished only matters in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_finished) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/control/destination latch; held from ISSUE until the next accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_input_a <= '0;
      alu_input_b <= '0;
      alu_control <= '0;
      dest_q      <= '0;
    end else if (accept) begin
      alu_input_a <= rs_val;
      alu_input_b <= dec_b;
      alu_control <= dec_ctrl;
      dest_q      <= dec_dest;
    end
  end

  // Capture ALU result and error flags on completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (state == WAIT && alu_finished) begin
      res_q <= alu_result;
      ovf_q <= alu_err_overflow;
      inv_q <= alu_err_invalid_control;
    end
  end

  // Decode-time reject pulse, visible the cycle after the offer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= reject;
  end

  // Only ADD/SUB (and ADDI, which decodes to ADD) trap on overflow
  assign signed_op = (alu_control == CTL_ADD) || (alu_control == CTL_SUB);

  assign instr_ready   = (state == IDLE);
  assign alu_start     = (state == ISSUE);
  assign overflow_trap = (state == WB) && !inv_q && ovf_q && signed_op;
  assign wb_valid      = (state == WB) && !inv_q && !(ovf_q && signed_op);
  assign illegal_instr = illegal_q || ((state == WB) && inv_q);
  assign wb_addr       = dest_q;
  assign wb_data       = res_q;
  assign wb_write      = wb_valid && (dest_q != '0);

  // Register file write at the end of WB; reset clears every entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_write) begin
      rf[dest_q] <= res_q;
    end
  end

endmodule
